// File: rtl/pcap_replay_ipg_shaper.sv
// rtl/pcap_replay_ipg_shaper.sv - gates a replay packet stream and inserts fixed idle gaps between packets
module pcap_replay_ipg_shaper #(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXI_DATA_WIDTH   = 32
) (
    input  logic                                axi_aclk,
    input  logic                                axi_reset,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    s_axis_tstrb,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser,
    input  logic                                s_axis_tvalid,
    input  logic                                s_axis_tlast,
    output logic                                s_axis_tready,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]    m_axis_tstrb,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser,
    output logic                                m_axis_tvalid,
    output logic                                m_axis_tlast,
    input  logic                                m_axis_tready,
    input  logic                                sw_rst,
    input  logic                                enable,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]       ipg_cycles,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]       pkt_limit,
    output logic [C_S_AXI_DATA_WIDTH-1:0]       pkt_count,
    output logic                                done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    localparam logic [C_S_AXI_DATA_WIDTH-1:0] C_CNT_MAX = '1;
    localparam logic [C_S_AXI_DATA_WIDTH-1:0] C_ONE     = {{(C_S_AXI_DATA_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]                    r_state;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_pkt_count;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_gap_cnt;
    logic                          r_done;

    logic                          w_send;
    logic                          w_pkt_end;
    logic [C_S_AXI_DATA_WIDTH-1:0] w_cnt_inc;
    logic                          w_limit_hit;

    // The stream is only connected while sending; sideband fields pass straight through.
    always_comb begin
        w_send        = (r_state == S_SEND);
        m_axis_tvalid = w_send & s_axis_tvalid;
        s_axis_tready = w_send & m_axis_tready;
        m_axis_tdata  = s_axis_tdata;
        m_axis_tstrb  = s_axis_tstrb;
        m_axis_tuser  = s_axis_tuser;
        m_axis_tlast  = s_axis_tlast;
        w_pkt_end     = m_axis_tvalid & m_axis_tready & s_axis_tlast;
        w_cnt_inc     = (r_pkt_count == C_CNT_MAX) ? r_pkt_count : r_pkt_count + C_ONE;
        w_limit_hit   = (pkt_limit != '0) && (w_cnt_inc == pkt_limit);
    end

    assign pkt_count = r_pkt_count;
    assign done      = r_done;

    // Packet-level sequencing: limits and gap length are only sampled at a packet end,
    // and an enable drop never cuts a packet short except through the software reset.
    always_ff @(posedge axi_aclk or posedge axi_reset) begin
        if (axi_reset) begin
            r_state     <= S_IDLE;
            r_pkt_count <= '0;
            r_gap_cnt   <= '0;
            r_done      <= 1'b0;
        end else if (sw_rst) begin
            r_state     <= S_IDLE;
            r_pkt_count <= '0;
            r_gap_cnt   <= '0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (enable && !r_done) begin
                        r_state <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (w_pkt_end) begin
                        r_pkt_count <= w_cnt_inc;
                        r_gap_cnt   <= ipg_cycles;
                        if (w_limit_hit) begin
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end else if (!enable) begin
                            r_state <= S_IDLE;
                        end else if (ipg_cycles == '0) begin
                            r_state <= S_SEND;
                        end else begin
                            r_state <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (!enable) begin
                        r_state   <= S_IDLE;
                        r_gap_cnt <= '0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - C_ONE;
                        if (r_gap_cnt <= C_ONE) begin
                            r_state <= S_SEND;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pcap_replay_ipg_shaper.sv
// tb/tb_pcap_replay_ipg_shaper.sv - directed self-checking bench for the replay gap shaper
module tb_pcap_replay_ipg_shaper;

    logic         axi_aclk = 1'b0;
    logic         axi_reset;
    logic [255:0] s_axis_tdata;
    logic [31:0]  s_axis_tstrb;
    logic [127:0] s_axis_tuser;
    logic         s_axis_tvalid;
    logic         s_axis_tlast;
    logic         s_axis_tready;
    logic [255:0] m_axis_tdata;
    logic [31:0]  m_axis_tstrb;
    logic [127:0] m_axis_tuser;
    logic         m_axis_tvalid;
    logic         m_axis_tlast;
    logic         m_axis_tready;
    logic         sw_rst;
    logic         enable;
    logic [31:0]  ipg_cycles;
    logic [31:0]  pkt_limit;
    logic [31:0]  pkt_count;
    logic         done;

    pcap_replay_ipg_shaper dut (
        .axi_aclk(axi_aclk), .axi_reset(axi_reset),
        .s_axis_tdata(s_axis_tdata), .s_axis_tstrb(s_axis_tstrb), .s_axis_tuser(s_axis_tuser),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tstrb(m_axis_tstrb), .m_axis_tuser(m_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
        .sw_rst(sw_rst), .enable(enable), .ipg_cycles(ipg_cycles), .pkt_limit(pkt_limit),
        .pkt_count(pkt_count), .done(done)
    );

    always #5 axi_aclk = ~axi_aclk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Upstream source: queue of beats, advanced on an observed handshake.
    logic [255:0] q_data[$];
    bit           q_last[$];
    bit           tog;
    bit           hs_pending;
    int           cyc;

    typedef struct {
        int           c;
        logic [255:0] d;
        bit           l;
    } beat_t;
    beat_t out_log[$];
    int    done_rise_cyc = -1;

    function automatic logic [255:0] beat(input int pid, input int idx);
        logic [31:0] w;
        w = {pid[15:0], idx[15:0]};
        return {8{w}};
    endfunction

    task automatic push_pkt(input int pid, input int n);
        for (int i = 0; i < n; i++) begin
            q_data.push_back(beat(pid, i));
            q_last.push_back(i == n - 1);
        end
    endtask

    task automatic drive();
        s_axis_tvalid = (q_data.size() > 0);
        s_axis_tdata  = (q_data.size() > 0) ? q_data[0] : '0;
        s_axis_tlast  = (q_last.size() > 0) ? q_last[0] : 1'b0;
        s_axis_tuser  = s_axis_tdata[127:0] ^ 128'h5a5a;
        s_axis_tstrb  = '1;
        m_axis_tready = tog ? ~m_axis_tready : 1'b1;
    endtask

    task automatic cycle();
        @(posedge axi_aclk);
        #1;
        if (hs_pending && q_data.size() > 0) begin
            void'(q_data.pop_front());
            void'(q_last.pop_front());
        end
        drive();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_swrst();
        sw_rst = 1'b1;
        cycle();
        sw_rst = 1'b0;
        q_data.delete();
        q_last.delete();
        drive();
    endtask

    // Reference model: is the gate open, how many idle cycles remain, packet count, done.
    bit          m_open;
    int unsigned m_gap;
    logic [31:0] m_cnt;
    bit          m_done;

    always @(posedge axi_aclk or posedge axi_reset) begin
        if (axi_reset) begin
            m_open = 0; m_gap = 0; m_cnt = 0; m_done = 0;
        end else begin
            cyc++;
            if (sw_rst) begin
                m_open = 0; m_gap = 0; m_cnt = 0; m_done = 0;
            end else if (m_open) begin
                if (s_axis_tvalid && m_axis_tready && s_axis_tlast) begin
                    if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
                    if (pkt_limit != 0 && m_cnt == pkt_limit) begin
                        m_done = 1; m_open = 0;
                    end else if (!enable) begin
                        m_open = 0;
                    end else if (ipg_cycles != 0) begin
                        m_open = 0; m_gap = ipg_cycles;
                    end
                end
            end else if (m_gap > 0) begin
                if (!enable) m_gap = 0;
                else begin
                    m_gap = m_gap - 1;
                    if (m_gap == 0) m_open = 1;
                end
            end else if (enable && !m_done) begin
                m_open = 1;
            end
        end
    end

    // Every cycle: DUT outputs against the model, pass-through fields, and logging of transfers.
    always @(negedge axi_aclk) begin
        chk("m_tvalid", m_axis_tvalid, m_open & s_axis_tvalid);
        chk("s_tready", s_axis_tready, m_open & m_axis_tready);
        chk("pkt_count", pkt_count, m_cnt);
        chk("done", done, m_done);
        if (m_axis_tvalid) begin
            chk("tdata", m_axis_tdata, s_axis_tdata);
            chk("tuser", m_axis_tuser, s_axis_tuser);
            chk("tstrb", m_axis_tstrb, s_axis_tstrb);
            chk("tlast", m_axis_tlast, s_axis_tlast);
        end
        if (done && done_rise_cyc < 0) done_rise_cyc = cyc;
        hs_pending = s_axis_tvalid & s_axis_tready;
        if (m_axis_tvalid && m_axis_tready) out_log.push_back('{cyc, m_axis_tdata, m_axis_tlast});
    end

    int base;
    int cnt0;
    bit ok;

    initial begin
        axi_reset = 1'b1; sw_rst = 1'b0; enable = 1'b0;
        ipg_cycles = 0; pkt_limit = 0; tog = 0; m_axis_tready = 1'b1; cyc = 0;
        drive();
        run(3);
        axi_reset = 1'b0;
        run(2);
        chk("reset pkt_count", pkt_count, 32'd0);
        chk("reset m_tvalid", m_axis_tvalid, 1'b0);
        chk("reset s_tready", s_axis_tready, 1'b0);

        // Back-to-back packets with no gap.
        push_pkt(1, 4); push_pkt(2, 4); push_pkt(3, 4);
        enable = 1'b1; drive();
        run(20);
        chk("b2b beats", out_log.size(), 12);
        if (out_log.size() == 12) chk("b2b contiguous", out_log[11].c - out_log[0].c, 11);
        chk("b2b pkt_count", pkt_count, 3);
        chk("b2b done", done, 0);
        enable = 1'b0;
        do_swrst();

        // Five idle cycles between two short packets.
        out_log.delete();
        ipg_cycles = 5; enable = 1'b1;
        push_pkt(4, 2); push_pkt(5, 2); drive();
        run(20);
        chk("gap beats", out_log.size(), 4);
        if (out_log.size() == 4) chk("gap length", out_log[2].c - out_log[1].c - 1, 5);
        chk("gap pkt_count", pkt_count, 2);
        enable = 1'b0;
        do_swrst();

        // Packet limit of two with four offered.
        out_log.delete(); done_rise_cyc = -1;
        ipg_cycles = 0; pkt_limit = 2; enable = 1'b1;
        for (int p = 0; p < 4; p++) push_pkt(16 + p, 2);
        drive();
        run(30);
        chk("limit beats", out_log.size(), 4);
        chk("limit done", done, 1);
        chk("limit s_tready", s_axis_tready, 0);
        chk("limit upstream still valid", s_axis_tvalid, 1);
        if (out_log.size() == 4) chk("done latency", done_rise_cyc, out_log[3].c + 1);
        enable = 1'b0; pkt_limit = 0;
        do_swrst();

        // Toggling downstream ready mid-packet.
        out_log.delete();
        enable = 1'b1; tog = 1;
        push_pkt(32, 6); push_pkt(33, 3); drive();
        run(40);
        chk("toggle beats", out_log.size(), 9);
        if (out_log.size() == 9) begin
            for (int i = 0; i < 9; i++)
                chk("toggle order", out_log[i].d, (i < 6) ? beat(32, i) : beat(33, i - 6));
        end
        chk("toggle pkt_count", pkt_count, 2);
        tog = 0; drive();

        // Enable dropped during beat 2 of a 4-beat packet.
        base = out_log.size(); cnt0 = pkt_count;
        push_pkt(48, 4); push_pkt(49, 4); drive();
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            cycle();
            if (out_log.size() >= base + 1) ok = 1;
        end
        chk("wait beat1 timeout", ok, 1);
        enable = 1'b0;
        run(15);
        chk("enable drop beats", out_log.size(), base + 4);
        if (out_log.size() == base + 4) begin
            chk("enable drop last data", out_log[base + 3].d, beat(48, 3));
            chk("enable drop last flag", out_log[base + 3].l, 1);
        end
        chk("enable drop pkt_count", pkt_count, cnt0 + 1);

        // Software reset in the middle of a packet.
        base = out_log.size();
        enable = 1'b1;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            cycle();
            if (out_log.size() >= base + 2) ok = 1;
        end
        chk("wait midpkt timeout", ok, 1);
        enable = 1'b0;
        do_swrst();
        chk("sw_rst pkt_count", pkt_count, 0);
        chk("sw_rst done", done, 0);
        chk("sw_rst m_tvalid", m_axis_tvalid, 0);

        // Asynchronous reset in the middle of a gap.
        base = out_log.size();
        ipg_cycles = 20; enable = 1'b1;
        push_pkt(64, 2); push_pkt(65, 2); drive();
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            cycle();
            if (out_log.size() >= base + 2) ok = 1;
        end
        chk("wait gap timeout", ok, 1);
        run(3);
        chk("pre async pkt_count", pkt_count, 1);
        #2;
        axi_reset = 1'b1;
        #1;
        chk("async pkt_count", pkt_count, 0);
        chk("async m_tvalid", m_axis_tvalid, 0);
        chk("async s_tready", s_axis_tready, 0);
        chk("async done", done, 0);
        enable = 1'b0;
        q_data.delete(); q_last.delete();
        run(2);
        axi_reset = 1'b0;
        run(2);
        base = out_log.size();
        ipg_cycles = 0; enable = 1'b1;
        push_pkt(80, 2); drive();
        run(10);
        chk("resume beats", out_log.size(), base + 2);
        chk("resume pkt_count", pkt_count, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
